// File: rtl/video_ega_pkg.sv
// Shared types and constants for the EGA plane-VRAM CPU-side port.
package video_ega_pkg;

  localparam int unsigned VRAM_ADDR_W = 14;
  localparam logic [3:0]  PLANES_ALL  = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arbStateT;

  // Plane strobes for one access: reads never drive a strobe.
  function automatic logic [3:0] wrStrobe(input logic we, input logic [3:0] mask);
    return we ? (mask & PLANES_ALL) : 4'h0;
  endfunction

endpackage

// File: rtl/video_ega_arb_pick.sv
// Winner select for the two VRAM requesters plus the starvation counter protecting B.
module video_ega_arb_pick
  import video_ega_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iDecide,
  input  logic iAReq,
  input  logic iBReq,
  output logic oGrantB_c
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starveCnt;

  // A has priority until B has watched LIMIT consecutive A grants go by.
  assign oGrantB_c = iBReq && (!iAReq || (starveCnt == LIMIT));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      starveCnt <= '0;
    end else if (iDecide) begin
      if (!iBReq || oGrantB_c) begin
        starveCnt <= '0;
      end else if (iAReq && (starveCnt != LIMIT)) begin
        starveCnt <= starveCnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/video_ega_vram_arb.sv
// Two-requester arbiter/sequencer for the EGA plane VRAM: one access at a time,
// write every 2 cycles, read data returned 3 cycles after the decision.
module video_ega_vram_arb
  import video_ega_pkg::*;
#(
  parameter int unsigned ADDR_W       = VRAM_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iAReq,
  input  logic              iAWe,
  input  logic [ADDR_W-1:0] iAAddr,
  input  logic [31:0]       iAWrData,
  input  logic [3:0]        iAWrMask,
  output logic              oAAck,
  output logic [31:0]       oARdData,
  output logic              oARdValid,
  input  logic              iBReq,
  input  logic              iBWe,
  input  logic [ADDR_W-1:0] iBAddr,
  input  logic [31:0]       iBWrData,
  input  logic [3:0]        iBWrMask,
  output logic              oBAck,
  output logic [31:0]       oBRdData,
  output logic              oBRdValid,
  output logic [ADDR_W-1:0] oVramAddr,
  output logic [3:0]        oVramWr,
  output logic [31:0]       oVramWrData,
  input  logic [31:0]       iVramRdData
);

  arbStateT state;
  logic     grantB;
  logic     isRead;
  logic     decide_c;
  logic     pickB_c;

  assign decide_c = (state == IDLE);

  video_ega_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uPick (
    .iClk     (iClk),
    .iRst     (iRst),
    .iDecide  (decide_c),
    .iAReq    (iAReq),
    .iBReq    (iBReq),
    .oGrantB_c(pickB_c)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      grantB      <= 1'b0;
      isRead      <= 1'b0;
      oAAck       <= 1'b0;
      oBAck       <= 1'b0;
      oARdData    <= '0;
      oBRdData    <= '0;
      oARdValid   <= 1'b0;
      oBRdValid   <= 1'b0;
      oVramAddr   <= '0;
      oVramWr     <= '0;
      oVramWrData <= '0;
    end else begin
      oAAck     <= 1'b0;
      oBAck     <= 1'b0;
      oARdValid <= 1'b0;
      oBRdValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iAReq || iBReq) begin
            grantB <= pickB_c;
            oAAck  <= !pickB_c;
            oBAck  <= pickB_c;
            if (pickB_c) begin
              oVramAddr   <= iBAddr;
              oVramWrData <= iBWrData;
              oVramWr     <= wrStrobe(iBWe, iBWrMask);
              isRead      <= !iBWe;
            end else begin
              oVramAddr   <= iAAddr;
              oVramWrData <= iAWrData;
              oVramWr     <= wrStrobe(iAWe, iAWrMask);
              isRead      <= !iAWe;
            end
            state <= ISSUE;
          end
        end
        // VRAM performs the access at the end of this cycle.
        ISSUE: begin
          oVramWr <= '0;
          state   <= isRead ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          if (grantB) begin
            oBRdData  <= iVramRdData;
            oBRdValid <= 1'b1;
          end else begin
            oARdData  <= iVramRdData;
            oARdValid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/video_ega_vram_arb.md
Name: video_ega_vram_arb

Overview:
- Two-requester arbiter and sequencer for the CPU-side port of the EGA plane VRAM (four 8-bit planes, 16K words x 32 bits, registered read).
- Shares the single read/write port between requester A (CPU/graphics-controller path, high priority) and requester B (background engine: fill, scroll, copy), with starvation protection for B.
- Sits between the EGA register/latch logic and the VRAM; issues one access at a time and returns read data with a fixed latency.

Parameters:
- ADDR_W, 14, VRAM word address width.
- STARVE_LIMIT, 4, consecutive A grants while B is pending before B is forced to win; range 1..7.

Ports:
- iClk  in  1  system clock; all logic on its rising edge.
- iRst  in  1  synchronous reset, active high.
- iAReq  in  1  requester A access request; level, sampled in IDLE.
- iAWe  in  1  A: 1 = write, 0 = read.
- iAAddr  in  ADDR_W  A word address.
- iAWrData  in  32  A write data, {plane3, plane2, plane1, plane0}.
- iAWrMask  in  4  A plane write enables, bit n = plane n.
- oAAck  out  1  A request accepted; one-cycle pulse.
- oARdData  out  32  A read data.
- oARdValid  out  1  oARdData valid; one-cycle pulse.
- iBReq, iBWe, iBAddr, iBWrData, iBWrMask, oBAck, oBRdData, oBRdValid: same as the A ports, for requester B.
- oVramAddr  out  ADDR_W  VRAM port address (registered).
- oVramWr  out  4  VRAM plane write strobes (registered).
- oVramWrData  out  32  VRAM write data (registered).
- iVramRdData  in  32  VRAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset values: all outputs 0. State IDLE, starvation counter 0, lastGrant = A.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE, no request: stay in IDLE. oVramWr = 0; oVramAddr holds its last value.
- IDLE, any request: pick the winner, then at the clock edge register oVramAddr, oVramWrData, and oVramWr (= mask if write, else 0). Go to ISSUE.
- Winner selection: A wins unless B is requesting and starveCnt == STARVE_LIMIT, in which case B wins. A lone requester always wins.
- ISSUE (cycle G+1, where G is the IDLE decision cycle):
  - the winner's oxAck = 1 for exactly this cycle;
  - VRAM address and strobes are valid, and the VRAM writes or latches its read at the end of this cycle;
  - next state and outputs at end of ISSUE: oVramWr cleared; write goes to IDLE; read goes to CAPTURE.
- CAPTURE (cycle G+2): register iVramRdData into the winner's oxRdData, go to IDLE. oxRdValid = 1 in cycle G+3, one cycle only.
- oxRdData holds its value until that requester's next read completes.
- Throughput and latency:
  - write: ack at G+1, next IDLE at G+2, one write per 2 cycles;
  - read: ack at G+1, data valid at G+3, one read per 3 cycles;
  - the read-data pulse coincides with the next IDLE decision cycle.
- Requester rules:
  - request signals must stay stable from assertion through the ack cycle;
  - a requester deasserts iXReq in the cycle after ack unless it has a new access;
  - a request still high in IDLE is treated as a new access;
  - request signals outside IDLE are ignored.
- Starvation counter (3 bits):
  - increments on each A grant made while iBReq = 1, saturating at STARVE_LIMIT;
  - clears on any B grant, and in any IDLE cycle where iBReq = 0.
- Write mask 0000 on a write: acked normally, no plane modified.
- Simultaneous events:
  - both requesting with starveCnt < STARVE_LIMIT: A wins, counter +1;
  - B not requesting: counter stays 0.
- Reset during ISSUE: the VRAM access at that edge still completes, and the ack already shown is not retracted. The FSM returns to IDLE, and no oxRdValid is produced for an in-flight read.
- Reset during CAPTURE: the read data is discarded.
- Address width: no wrap logic; ADDR_W bits are passed through unmodified.

Decomposition:
- Shared package video_ega_pkg:
  - FSM state encoding (IDLE=0, ISSUE=1, CAPTURE=2);
  - VRAM_ADDR_W = 14;
  - plane mask constant PLANES_ALL = 4'hF.
- One sub-module is natural: video_ega_arb_pick, a combinational winner select plus registered starvation counter. Everything else stays flat.

Test Plan:
- Single A write, addr 0x0123, data 0xDEADBEEF, mask 1111 -> oAAck at G+1; oVramAddr=0x0123, oVramWr=1111, oVramWrData=0xDEADBEEF in G+1; oVramWr=0 at G+2.
- A read at 0x1FFF with VRAM model returning 0xA5A5_5A5A -> oAAck at G+1, oARdValid=1 at G+3, oARdData=0xA5A55A5A; oBRdValid stays 0.
- A and B held requesting continuously, STARVE_LIMIT=4 -> grant order A,A,A,A,B,A,A,A,A,B; counter returns to 0 after each B grant.
- B alone, write with mask 0000 -> oBAck pulses, oVramWr stays 0000 for the whole transaction.
- Assert iRst in the ISSUE cycle of a B read -> no oBRdValid, all outputs 0 the next cycle, state IDLE; a new A read afterwards completes with 3-cycle latency.
- Back-to-back A writes with req held high -> one ack every 2 cycles, 4 writes in 8 cycles, addresses in order.
